// File: rtl/exec_alu_stage.sv
// ----------------------------------------------------------------------------
// exec_alu_stage
//   Execute stage of a single-cycle LEGv8-style core. It decodes the ALU
//   control code from ALUOp and the instruction opcode, runs the 64-bit ALU
//   with a zero flag, and forms PC+4 and the branch target. It then selects
//   the next PC from branch & zero. Every output is registered, so each
//   result appears one clock after its inputs.
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset (clears all outputs)
//   pc            in   current instruction address
//   reg_data_1    in   ALU operand A (Rn)
//   reg_data_2    in   register operand B (Rm/Rt)
//   sign_ext_imm  in   sign-extended immediate / branch offset in words
//   alu_src       in   0: B = reg_data_2, 1: B = sign_ext_imm
//   alu_op        in   ALUOp from the control unit
//   opcode        in   instruction[31:21]
//   branch        in   conditional-branch instruction flag
//   alu_ctrl      out  decoded ALU operation
//   alu_result    out  ALU result
//   zero          out  ALU result equals zero
//   pc_plus4      out  pc + 4
//   branch_target out  pc + (sign_ext_imm << 2)
//   next_pc       out  branch & zero ? branch_target : pc_plus4
// ----------------------------------------------------------------------------
module exec_alu_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] reg_data_1,
    input  logic [WIDTH-1:0] reg_data_2,
    input  logic [WIDTH-1:0] sign_ext_imm,
    input  logic             alu_src,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic             branch,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] next_pc
);

    logic [3:0]       w_alu_ctrl;
    logic [WIDTH-1:0] w_operand_b;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_zero;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_branch_target;
    logic [WIDTH-1:0] w_next_pc;

    logic [3:0]       r_alu_ctrl;
    logic [WIDTH-1:0] r_alu_result;
    logic             r_zero;
    logic [WIDTH-1:0] r_pc_plus4;
    logic [WIDTH-1:0] r_branch_target;
    logic [WIDTH-1:0] r_next_pc;

    // Map ALUOp and the R-type opcode to a 4-bit ALU control code.
    function automatic logic [3:0] decode_alu_ctrl(input logic [1:0]  op,
                                                   input logic [10:0] opc);
        logic [3:0] ctrl;
        case (op)
            2'b00:   ctrl = 4'b0010;
            2'b01:   ctrl = 4'b0111;
            2'b11:   ctrl = 4'b0010;
            2'b10: begin
                case (opc)
                    11'b10001011000: ctrl = 4'b0010;
                    11'b11001011000: ctrl = 4'b0110;
                    11'b10001010000: ctrl = 4'b0000;
                    11'b10101010000: ctrl = 4'b0001;
                    default:         ctrl = 4'b1111;
                endcase
            end
            default: ctrl = 4'b1111;
        endcase
        return ctrl;
    endfunction

    // ALU operation. Unused control codes produce 0.
    function automatic logic [WIDTH-1:0] alu_compute(input logic [3:0]       ctrl,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        case (ctrl)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: res = a + b;
            4'b0110: res = a - b;
            4'b0111: res = b;
            4'b1100: res = ~(a | b);
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    // Combinational execute datapath for the current inputs.
    always_comb begin
        w_alu_ctrl      = decode_alu_ctrl(alu_op, opcode);
        if (alu_src) begin
            w_operand_b = sign_ext_imm;
        end else begin
            w_operand_b = reg_data_2;
        end
        w_alu_result    = alu_compute(w_alu_ctrl, reg_data_1, w_operand_b);
        w_zero          = (w_alu_result == {WIDTH{1'b0}});
        w_pc_plus4      = pc + WIDTH'(4);
        // The word offset becomes a byte offset. The top two immediate bits
        // fall off, and the add wraps modulo 2^WIDTH.
        w_branch_target = pc + {sign_ext_imm[WIDTH-3:0], 2'b00};
        if (branch && w_zero) begin
            w_next_pc   = w_branch_target;
        end else begin
            w_next_pc   = w_pc_plus4;
        end
    end

    // Output registers: capture every cycle, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_ctrl      <= 4'b0000;
            r_alu_result    <= {WIDTH{1'b0}};
            r_zero          <= 1'b0;
            r_pc_plus4      <= {WIDTH{1'b0}};
            r_branch_target <= {WIDTH{1'b0}};
            r_next_pc       <= {WIDTH{1'b0}};
        end else begin
            r_alu_ctrl      <= w_alu_ctrl;
            r_alu_result    <= w_alu_result;
            r_zero          <= w_zero;
            r_pc_plus4      <= w_pc_plus4;
            r_branch_target <= w_branch_target;
            r_next_pc       <= w_next_pc;
        end
    end

    assign alu_ctrl      = r_alu_ctrl;
    assign alu_result    = r_alu_result;
    assign zero          = r_zero;
    assign pc_plus4      = r_pc_plus4;
    assign branch_target = r_branch_target;
    assign next_pc       = r_next_pc;

endmodule

// File: tb/tb_exec_alu_stage.sv
// ----------------------------------------------------------------------------
// tb_exec_alu_stage
//   Table-driven bench for exec_alu_stage. Each vector holds its inputs and
//   hand-computed expected outputs. When a vector is driven, its expected
//   outputs are pushed to a scoreboard queue. They are popped and compared
//   one cycle later. Hand-written sequences cover the asynchronous reset and
//   a reset landing while a result is in flight.
// ----------------------------------------------------------------------------
module tb_exec_alu_stage;

    localparam int W = 64;
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_BAD = 11'b11111111111;
    localparam logic [10:0] OPC_CBZ = 11'b10110100000;
    localparam int NVEC = 13;

    typedef struct {
        logic [1:0]   alu_op;
        logic [10:0]  opcode;
        logic         alu_src;
        logic         branch;
        logic [W-1:0] pc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] imm;
        logic [3:0]   e_ctrl;
        logic [W-1:0] e_res;
        logic         e_zero;
        logic [W-1:0] e_p4;
        logic [W-1:0] e_tgt;
        logic [W-1:0] e_next;
    } vec_t;

    typedef struct {
        logic [3:0]   ctrl;
        logic [W-1:0] res;
        logic         zero;
        logic [W-1:0] p4;
        logic [W-1:0] tgt;
        logic [W-1:0] next;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] pc;
    logic [W-1:0] reg_data_1;
    logic [W-1:0] reg_data_2;
    logic [W-1:0] sign_ext_imm;
    logic         alu_src;
    logic [1:0]   alu_op;
    logic [10:0]  opcode;
    logic         branch;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_result;
    logic         zero;
    logic [W-1:0] pc_plus4;
    logic [W-1:0] branch_target;
    logic [W-1:0] next_pc;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs [NVEC];
    exp_t sb_q [$];

    exec_alu_stage #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc           (pc),
        .reg_data_1   (reg_data_1),
        .reg_data_2   (reg_data_2),
        .sign_ext_imm (sign_ext_imm),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .opcode       (opcode),
        .branch       (branch),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .zero         (zero),
        .pc_plus4     (pc_plus4),
        .branch_target(branch_target),
        .next_pc      (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alu_ctrl"}, W'(alu_ctrl), 64'd0);
        check({tag, ".alu_result"}, alu_result, 64'd0);
        check({tag, ".zero"}, W'(zero), 64'd0);
        check({tag, ".pc_plus4"}, pc_plus4, 64'd0);
        check({tag, ".branch_target"}, branch_target, 64'd0);
        check({tag, ".next_pc"}, next_pc, 64'd0);
    endtask

    task automatic drive(input vec_t v);
        alu_op       = v.alu_op;
        opcode       = v.opcode;
        alu_src      = v.alu_src;
        branch       = v.branch;
        pc           = v.pc;
        reg_data_1   = v.a;
        reg_data_2   = v.b;
        sign_ext_imm = v.imm;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.ctrl = v.e_ctrl;
        e.res  = v.e_res;
        e.zero = v.e_zero;
        e.p4   = v.e_p4;
        e.tgt  = v.e_tgt;
        e.next = v.e_next;
        sb_q.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s.scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".alu_ctrl"}, W'(alu_ctrl), W'(e.ctrl));
            check({tag, ".alu_result"}, alu_result, e.res);
            check({tag, ".zero"}, W'(zero), W'(e.zero));
            check({tag, ".pc_plus4"}, pc_plus4, e.p4);
            check({tag, ".branch_target"}, branch_target, e.tgt);
            check({tag, ".next_pc"}, next_pc, e.next);
        end
    endtask

    initial begin
        // alu_op, opcode, src, br, pc, a, b, imm | ctrl, res, zero, p4, tgt, next
        vecs[0]  = '{2'b10, OPC_ADD, 1'b0, 1'b0, 64'h0, 64'd5, 64'd7, 64'd0,
                     4'b0010, 64'd12, 1'b0, 64'h4, 64'h0, 64'h4};
        vecs[1]  = '{2'b10, OPC_SUB, 1'b0, 1'b1, 64'h40, 64'h1234, 64'h1234, 64'd3,
                     4'b0110, 64'd0, 1'b1, 64'h44, 64'h4C, 64'h4C};
        vecs[2]  = '{2'b10, OPC_SUB, 1'b0, 1'b1, 64'h40, 64'd0, 64'd1, 64'd3,
                     4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h44, 64'h4C, 64'h44};
        vecs[3]  = '{2'b10, OPC_AND, 1'b0, 1'b0, 64'h0, 64'hF0, 64'h3C, 64'd0,
                     4'b0000, 64'h30, 1'b0, 64'h4, 64'h0, 64'h4};
        vecs[4]  = '{2'b10, OPC_ORR, 1'b0, 1'b0, 64'h0, 64'hF0, 64'h3C, 64'd0,
                     4'b0001, 64'hFC, 1'b0, 64'h4, 64'h0, 64'h4};
        vecs[5]  = '{2'b10, OPC_BAD, 1'b0, 1'b0, 64'h200, 64'hF0, 64'h3C, 64'd0,
                     4'b1111, 64'd0, 1'b1, 64'h204, 64'h200, 64'h204};
        vecs[6]  = '{2'b01, OPC_CBZ, 1'b0, 1'b1, 64'h100, 64'h55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE,
                     4'b0111, 64'd0, 1'b1, 64'h104, 64'hF8, 64'hF8};
        vecs[7]  = '{2'b01, OPC_CBZ, 1'b0, 1'b1, 64'h100, 64'h55, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE,
                     4'b0111, 64'd3, 1'b0, 64'h104, 64'hF8, 64'h104};
        vecs[8]  = '{2'b00, OPC_ADD, 1'b1, 1'b0, 64'h10, 64'h1000, 64'h999, 64'd8,
                     4'b0010, 64'h1008, 1'b0, 64'h14, 64'h30, 64'h14};
        vecs[9]  = '{2'b11, OPC_BAD, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 64'd2, 64'd1,
                     4'b0010, 64'd3, 1'b0, 64'h0, 64'h0, 64'h0};
        vecs[10] = '{2'b11, OPC_ADD, 1'b0, 1'b1, 64'h100, 64'd0, 64'd0, 64'hC000_0000_0000_0002,
                     4'b0010, 64'd0, 1'b1, 64'h104, 64'h108, 64'h108};
        vecs[11] = '{2'b10, OPC_SUB, 1'b1, 1'b1, 64'h0, 64'd10, 64'hABC, 64'd3,
                     4'b0110, 64'd7, 1'b0, 64'h4, 64'hC, 64'h4};
        vecs[12] = '{2'b10, OPC_AND, 1'b0, 1'b1, 64'h20, 64'hF0, 64'h0F, 64'd4,
                     4'b0000, 64'd0, 1'b1, 64'h24, 64'h30, 64'h30};

        // Reset asserted with non-zero inputs: outputs are zero before any edge.
        reset_n = 1'b0;
        drive(vecs[6]);
        #2;
        check_all_zero("reset_initial");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        @(negedge clk);
        reset_n = 1'b1;

        // Table vectors, one per cycle, through the scoreboard.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            push_exp(vecs[i]);
            @(posedge clk);
            #1;
            pop_compare($sformatf("vec%0d", i));
        end

        // Reset mid-operation: in-flight outputs clear without a clock edge.
        @(negedge clk);
        drive(vecs[0]);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_async_mid");
        @(posedge clk);
        #1;
        check_all_zero("reset_mid_hold");
        @(negedge clk);
        reset_n = 1'b1;
        drive(vecs[4]);
        push_exp(vecs[4]);
        @(posedge clk);
        #1;
        pop_compare("after_reset");

        // Back-to-back vectors: each output tracks the previous cycle's inputs.
        @(negedge clk);
        drive(vecs[6]);
        push_exp(vecs[6]);
        @(posedge clk);
        #1;
        pop_compare("b2b_cbz_taken");
        @(negedge clk);
        drive(vecs[7]);
        push_exp(vecs[7]);
        @(posedge clk);
        #1;
        pop_compare("b2b_cbz_not_taken");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
